// File: rtl/snake_body_tracker.sv
// snake_body_tracker: head-position history with wall/self collision, food growth and an indexed segment read port.
module snake_body_tracker #(
  parameter int MAX_LEN   = 64,
  parameter int INIT_LEN  = 20,
  parameter int GROW_STEP = 1,
  parameter int X_MIN     = 0,
  parameter int X_MAX     = 639,
  parameter int Y_MIN     = 0,
  parameter int Y_MAX     = 479
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        iIconTick,
  input  logic [10:0] iHeadX,
  input  logic [10:0] iHeadY,
  input  logic [10:0] iFoodX,
  input  logic [10:0] iFoodY,
  input  logic        iFoodValid,
  input  logic [7:0]  iSegIndex,
  output logic [10:0] oSegX,
  output logic [10:0] oSegY,
  output logic        oSegValid,
  output logic [7:0]  oSnakeLenght,
  output logic        oGameOver,
  output logic        oFoodEaten,
  output logic        oBusy
);
  localparam int AW = $clog2(MAX_LEN);
  typedef enum logic [2:0] {IDLE, LATCH, SCAN, CHECK, WRITE} state_t;
  state_t        r_state, w_next;
  logic [21:0]   r_mem [MAX_LEN];
  logic [AW-1:0] r_wrptr;
  logic [7:0]    r_hist, r_n, r_k;
  logic [10:0]   r_hx, r_hy;
  logic          r_coll;
  logic [AW-1:0] w_scan_addr, w_rd_addr;
  logic [7:0]    w_lim_scan, w_lim_rd, w_len_inc;
  logic          w_match, w_wall, w_food;
  // Address of the entry k steps back from the newest one, wrapping modulo MAX_LEN.
  function automatic logic [AW-1:0] back(input logic [AW-1:0] p, input logic [7:0] k);
    int t;
    t = int'(p) + MAX_LEN - 1 - (int'(k) % MAX_LEN);
    return AW'(t >= MAX_LEN ? t - MAX_LEN : t);
  endfunction
  assign w_scan_addr = back(r_wrptr, r_k);
  assign w_rd_addr   = back(r_wrptr, iSegIndex);
  assign w_lim_scan  = (r_hist < oSnakeLenght - 8'd1) ? r_hist : oSnakeLenght - 8'd1;
  assign w_lim_rd    = (r_hist < oSnakeLenght) ? r_hist : oSnakeLenght;
  assign w_len_inc   = (int'(oSnakeLenght) + GROW_STEP >= MAX_LEN) ? 8'(MAX_LEN) : oSnakeLenght + 8'(GROW_STEP);
  assign w_match     = r_mem[w_scan_addr] == {r_hx, r_hy};
  assign w_wall      = int'(r_hx) < X_MIN || int'(r_hx) > X_MAX || int'(r_hy) < Y_MIN || int'(r_hy) > Y_MAX;
  assign w_food      = iFoodValid && r_hx == iFoodX && r_hy == iFoodY;
  assign oBusy       = r_state != IDLE;
  assign oFoodEaten  = r_state == CHECK && !w_wall && !r_coll && w_food;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = (iIconTick && !oGameOver) ? LATCH : IDLE;
      LATCH:   w_next = (w_lim_scan == 8'd0) ? CHECK : SCAN;
      SCAN:    w_next = (w_match || r_k == r_n - 8'd1) ? CHECK : SCAN;
      CHECK:   w_next = (w_wall || r_coll) ? IDLE : WRITE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state      <= IDLE;
      r_wrptr      <= '0;
      r_hist       <= '0;
      r_n          <= '0;
      r_k          <= '0;
      r_hx         <= '0;
      r_hy         <= '0;
      r_coll       <= 1'b0;
      oSnakeLenght <= 8'(INIT_LEN);
      oGameOver    <= 1'b0;
      oSegX        <= '0;
      oSegY        <= '0;
      oSegValid    <= 1'b0;
    end else begin
      r_state   <= w_next;
      oSegX     <= r_mem[w_rd_addr][21:11];
      oSegY     <= r_mem[w_rd_addr][10:0];
      oSegValid <= iSegIndex < w_lim_rd;
      case (r_state)
        LATCH: begin
          r_hx   <= iHeadX;
          r_hy   <= iHeadY;
          r_n    <= w_lim_scan;
          r_k    <= '0;
          r_coll <= 1'b0;
        end
        SCAN: begin
          r_k <= r_k + 8'd1;
          if (w_match) r_coll <= 1'b1;
        end
        CHECK: begin
          if (w_wall || r_coll) oGameOver <= 1'b1;
          else if (w_food) oSnakeLenght <= w_len_inc;
        end
        WRITE: begin
          r_wrptr <= (r_wrptr == AW'(MAX_LEN - 1)) ? '0 : r_wrptr + AW'(1);
          r_hist  <= (int'(r_hist) >= MAX_LEN) ? r_hist : r_hist + 8'd1;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge Clock) begin
    if (r_state == WRITE) r_mem[r_wrptr] <= {r_hx, r_hy};
  end
endmodule

// File: tb/tb_snake_body_tracker.sv
// tb_snake_body_tracker: scoreboard bench for snake_body_tracker, with a second INIT_LEN=4 instance for the loop case.
module tb_snake_body_tracker;
  logic clk = 0, rst = 1, tick = 0, fv = 0;
  logic [10:0] hx = 0, hy = 0, fx = 0, fy = 0;
  logic [7:0] idx = 0;
  logic [10:0] sx, sy, sx4, sy4;
  logic sv, go, fe, busy, sv4, go4, fe4, busy4;
  logic [7:0] len, len4;
  int n_cmp = 0, n_bad = 0;
  int mx[$], my[$];
  int exq[$];
  int mlen = 20;
  bit mgo = 0;

  snake_body_tracker u_dut (
    .Clock(clk), .Reset(rst), .iIconTick(tick), .iHeadX(hx), .iHeadY(hy),
    .iFoodX(fx), .iFoodY(fy), .iFoodValid(fv), .iSegIndex(idx),
    .oSegX(sx), .oSegY(sy), .oSegValid(sv), .oSnakeLenght(len),
    .oGameOver(go), .oFoodEaten(fe), .oBusy(busy));

  snake_body_tracker #(.INIT_LEN(4)) u_dut4 (
    .Clock(clk), .Reset(rst), .iIconTick(tick), .iHeadX(hx), .iHeadY(hy),
    .iFoodX(fx), .iFoodY(fy), .iFoodValid(fv), .iSegIndex(idx),
    .oSegX(sx4), .oSegY(sy4), .oSegValid(sv4), .oSnakeLenght(len4),
    .oGameOver(go4), .oFoodEaten(fe4), .oBusy(busy4));

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mx.delete();
    my.delete();
    mlen = 20;
    mgo = 0;
  endtask

  function automatic bit hits(int x, int y, int win);
    int n;
    n = (mx.size() < win) ? mx.size() : win;
    for (int i = 0; i < n; i++) if (mx[i] == x && my[i] == y) return 1;
    return 0;
  endfunction

  task automatic tick_at(input int x, input int y, input bit chk4);
    bit wall, coll, coll4, eat;
    int pulses, cyc;
    wall  = x > 639 || y > 479;
    coll  = hits(x, y, mlen - 1);
    coll4 = hits(x, y, 3);
    eat   = !mgo && !wall && !coll && fv && fx == x && fy == y;
    exq.push_back(mgo ? 0 : 1);
    exq.push_back(eat);
    if (!mgo) begin
      if (wall || coll) mgo = 1;
      else begin
        if (eat) mlen = (mlen + 1 > 64) ? 64 : mlen + 1;
        mx.push_front(x);
        my.push_front(y);
        if (mx.size() > 64) begin
          void'(mx.pop_back());
          void'(my.pop_back());
        end
      end
    end
    exq.push_back(mlen);
    exq.push_back(mgo);
    hx = 11'(x);
    hy = 11'(y);
    tick = 1;
    @(posedge clk); #1;
    tick = 0;
    check("busy_after_tick", busy, exq.pop_front());
    pulses = 0;
    cyc = 0;
    while (busy && cyc < 200) begin
      pulses += int'(fe);
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 200) check("idle_timeout", cyc, 0);
    check("food_pulses", pulses, exq.pop_front());
    check("length", len, exq.pop_front());
    check("game_over", go, exq.pop_front());
    if (chk4) check("game_over_len4", go4, coll4);
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic read_seg(input int i);
    int v;
    v = (i < ((mx.size() < mlen) ? mx.size() : mlen)) ? 1 : 0;
    exq.push_back(v);
    exq.push_back(v ? mx[i] : 0);
    exq.push_back(v ? my[i] : 0);
    idx = 8'(i);
    @(posedge clk); #1;
    v = exq.pop_front();
    check($sformatf("seg_valid[%0d]", i), sv, v);
    if (v) begin
      check($sformatf("seg_x[%0d]", i), sx, exq.pop_front());
      check($sformatf("seg_y[%0d]", i), sy, exq.pop_front());
    end else begin
      void'(exq.pop_front());
      void'(exq.pop_front());
    end
  endtask

  task automatic do_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_len", len, 20);
    check("rst_go", go, 0);
    check("rst_busy", busy, 0);
    check("rst_fe", fe, 0);
    check("rst_segx", sx, 0);
    check("rst_segv", sv, 0);
    rst = 0;
    model_clear();
    read_seg(0);
    read_seg(5);
    read_seg(63);

    tick_at(300, 300, 1);
    tick_at(301, 300, 1);
    tick_at(301, 301, 1);
    tick_at(300, 301, 1);
    tick_at(300, 300, 1);
    check("loop_go", go, 1);
    tick_at(302, 302, 0);

    do_reset();
    tick_at(100, 100, 0);
    tick_at(101, 100, 0);
    tick_at(102, 100, 0);
    hx = 103;
    hy = 100;
    tick = 1;
    @(posedge clk); #1;
    tick = 0;
    @(posedge clk); #1;
    check("scan_busy", busy, 1);
    rst = 1;
    #1;
    check("midscan_len", len, 20);
    check("midscan_go", go, 0);
    check("midscan_busy", busy, 0);
    check("midscan_fe", fe, 0);
    check("midscan_segx", sx, 0);
    check("midscan_segv", sv, 0);
    @(posedge clk); #1;
    rst = 0;
    model_clear();

    for (int i = 0; i < 5; i++) tick_at(241 + i, 350, 0);
    read_seg(0);
    read_seg(4);
    read_seg(5);

    fx = 246;
    fy = 350;
    fv = 1;
    tick_at(246, 350, 0);
    tick_at(247, 350, 0);

    for (int i = 0; i < 60; i++) begin
      fx = 11'(248 + i);
      tick_at(248 + i, 350, 0);
    end
    check("sat_len", len, 64);
    read_seg(0);
    read_seg(1);
    read_seg(63);
    read_seg(64);
    fv = 0;

    tick_at(0, 350, 0);
    read_seg(0);
    tick_at(2047, 350, 0);
    read_seg(0);
    tick_at(1, 350, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/snake_body_tracker.md
Name: snake_body_tracker

Overview:
- Consumes the head position and movement tick from the snake movement unit.
- Keeps a history buffer of past head positions that forms the snake body.
- Detects wall and self collisions and food consumption, and drives the game-over flag and snake length back to the movement unit.
- Provides an indexed segment read port for the VGA renderer.

Parameters:
MAX_LEN, 64, history buffer depth and length ceiling (2..255)
INIT_LEN, 20, snake length after reset (1..MAX_LEN)
GROW_STEP, 1, length increment per food eaten
X_MIN, 0, leftmost legal head X
X_MAX, 639, rightmost legal head X
Y_MIN, 0, topmost legal head Y
Y_MAX, 479, bottom legal head Y

Ports:
Clock  in  1  system clock
Reset  in  1  asynchronous, active-high reset
iIconTick  in  1  one-cycle movement tick; head position updates on this tick
iHeadX  in  11  current head X
iHeadY  in  11  current head Y
iFoodX  in  11  food X
iFoodY  in  11  food Y
iFoodValid  in  1  food is currently placed
iSegIndex  in  8  segment read index; 0 = most recent head
oSegX  out  11  X of the addressed segment (registered)
oSegY  out  11  Y of the addressed segment (registered)
oSegValid  out  1  addressed segment is part of the current body
oSnakeLenght  out  8  current length
oGameOver  out  1  sticky collision flag
oFoodEaten  out  1  one-cycle pulse when food is eaten
oBusy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset values (async, immediate):
  - oSnakeLenght = INIT_LEN; oGameOver = 0; oFoodEaten = 0; oBusy = 0; oSegX/Y = 0; oSegValid = 0.
  - Write pointer = 0; history count rHist = 0; FSM in IDLE; collision flag cleared.
  - Buffer contents are don't-care.
- FSM states: IDLE, LATCH, SCAN, CHECK, WRITE.
- IDLE:
  - If iIconTick=1 and oGameOver=0, go to LATCH.
  - Ticks are ignored when oGameOver=1 or the FSM is not in IDLE. No queueing.
- LATCH:
  - Waits one cycle after the tick so the head position can settle.
  - Captures iHeadX/iHeadY into rHead.
  - Sets scan count N = min(rHist, oSnakeLenght-1) and k = 0.
  - Goes to SCAN, or to CHECK if N = 0.
- SCAN:
  - One history entry per cycle, newest first: entry k is at address (wrptr-1-k) mod MAX_LEN.
  - Sets the collision flag if the entry equals rHead on both X and Y.
  - k increments each cycle; goes to CHECK after entry N-1.
  - The scan finishes early when a match is found.
- CHECK, in a single cycle:
  - Wall violation: rHead.X < X_MIN, rHead.X > X_MAX, rHead.Y < Y_MIN or rHead.Y > Y_MAX. Comparisons are unsigned 11-bit, so a decrement from 0 wraps to 2047 and counts as a violation.
  - If wall violation or collision flag: oGameOver <= 1 and go to IDLE. No write, no growth.
  - Otherwise, if iFoodValid and rHead equals (iFoodX, iFoodY): oFoodEaten = 1 for exactly this cycle, and oSnakeLenght += GROW_STEP, saturating at MAX_LEN.
  - Then go to WRITE.
- WRITE:
  - Stores rHead at wrptr; wrptr increments modulo MAX_LEN.
  - rHist increments, saturating at MAX_LEN.
  - Goes to IDLE.
- Worst-case latency from tick to IDLE is MAX_LEN+4 cycles. Callers must space ticks at least MAX_LEN+8 cycles apart.
- oGameOver is sticky until Reset. Once set, oSnakeLenght and the buffer are frozen.
- Read port:
  - oSegX/oSegY update one cycle after iSegIndex, from address (wrptr-1-iSegIndex) mod MAX_LEN.
  - oSegValid = (iSegIndex < min(rHist, oSnakeLenght)), registered with the same 1-cycle latency.
  - The read port operates in every state; during WRITE it returns the pre-write contents.
- Reset asserted in any state (including mid-SCAN) returns all outputs to their reset values immediately. The first tick after Reset is deasserted is accepted normally.

Test Plan:
- Assert and release Reset → oSnakeLenght=20, oGameOver=0, oBusy=0, oFoodEaten=0, oSegValid=0 for every index.
- Send 5 ticks, with head moving east from (241,350) to (245,350) and ticks 200 cycles apart → iSegIndex=0 returns (245,350) and index 4 returns (241,350), both with oSegValid=1; index 5 returns oSegValid=0.
- Food at (246,350) with iFoodValid=1; next tick with head at (246,350) → oFoodEaten high for exactly 1 cycle and oSnakeLenght=21. A further tick with head at (247,350) → no pulse, length stays 21.
- Head X moves from 0 to 2047 on a tick → oGameOver=1 within 4+N cycles, no write (index 0 unchanged). Further ticks leave oBusy=0 and the length unchanged.
- Drive the 4-cell loop (300,300), (301,300), (301,301), (300,301), then (300,300) again, with length 20 → oGameOver=1 on the fifth tick. The same loop with INIT_LEN=4 → no game over, because the revisited cell is outside the length-1 window.
- Reset pulsed while oBusy=1 in SCAN → all outputs return to reset values at once. Growth run with MAX_LEN=64 and 50 food hits → oSnakeLenght saturates at 64. The buffer wraps correctly: index 0 is always the latest head.
